dac_frame_sequencer: RTL and testbench
======================================

# dac_frame_sequencer

Controller for the serial DAC path of the sine generator. On each sample tick it reads one sample from the sine ROM at an address taken from a phase accumulator. It then shifts the sample MSB-first into the serial-input DAC, strobes start-of-conversion, and advances the phase by a programmable frequency word. It sits between the tick counter and the ROM/serial DAC pair, running in the 200 MHz PLL domain.

## Interface
- DATA_W, 12: sample width = serial bits per frame
- ADDR_W, 8: ROM address width
- PHASE_W, 16: phase accumulator width (≥ ADDR_W)
- clk  in  1  sequencer clock (PLL output)
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; low aborts/holds
- tick  in  1  one-cycle sample strobe from tick counter
- freq_word  in  PHASE_W  phase increment per sample
- rom_addr  out  ADDR_W  ROM read address (registered)
- rom_data  in  DATA_W  ROM read data, valid one cycle after rom_addr
- SO  out  1  serial data to DAC SI
- SI_en  out  1  serial data valid / shift enable to DAC
- soc  out  1  one-cycle start-of-conversion to DAC
- busy  out  1  frame in progress
- overrun  out  1  one-cycle pulse: tick arrived while busy

## Operation
- Reset (async, rst_n=0): state IDLE; phase=0, rom_addr=0, shift reg=0, bit count=0; SO, SI_en, soc, busy, overrun all 0.
- FSM states: IDLE, FETCH, WAIT, SHIFT, CONVERT.
- IDLE: busy=0. On en=1 && tick=1:
  - capture freq_word into freq_q;
  - load rom_addr = phase[PHASE_W-1 -: ADDR_W];
  - go to FETCH.
- FETCH: ROM access cycle → WAIT.
- WAIT: load rom_data into shift reg; bit count = DATA_W-1 → SHIFT.
- SHIFT: SO = shift reg MSB, SI_en=1. Shift left each cycle and decrement count. Leave at count 0 after exactly DATA_W cycles → CONVERT.
- CONVERT: soc=1, SI_en=0, phase ← phase + freq_q (mod 2^PHASE_W, natural wrap) → IDLE.
- freq_word changes mid-frame do not affect the current frame.
- tick while state ≠ IDLE: tick is dropped, overrun=1 for that cycle, frame continues unaffected.
- en=0 in any non-IDLE state: next cycle → IDLE.
  - SO/SI_en/soc forced 0 from that cycle.
  - phase not advanced.
  - rom_addr holds.
- en=0 in IDLE: ticks ignored, no overrun.
- SO=0 whenever SI_en=0.

## Timing
- Cycle 0: tick sampled high in IDLE.
- Cycle 1: FETCH, rom_addr valid, busy=1.
- Cycle 2: WAIT, rom_data captured at end of cycle.
- Cycles 3 … 2+DATA_W: SHIFT. Cycle 3+k carries bit DATA_W-1-k.
- Cycle 3+DATA_W: CONVERT, soc=1, phase updated at end of cycle.
- Cycle 4+DATA_W: IDLE, busy=0. A tick here starts the next frame, so the minimum tick period is DATA_W+4 cycles (16 for defaults).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package sine_dac_pkg:
  - state enum seq_state_t {IDLE, FETCH, WAIT, SHIFT, CONVERT};
  - default constants SINE_DATA_W=12, SINE_ADDR_W=8, SINE_PHASE_W=16.
- Sub-module dac_piso: parallel-load, MSB-first shift register.
  - Ports: load, shift, d[DATA_W-1:0], q_msb.
  - Instantiated once.
- FSM, bit counter and phase accumulator stay in dac_frame_sequencer.

## Test plan
- Basic frame: rst_n released, en=1, freq_word=16'h0100, ROM[0]=12'hA5C, single tick.
  - rom_addr=0 at cycle 1.
  - SO pattern 1010_0101_1100 over cycles 3–14 with SI_en=1.
  - soc=1 only at cycle 15, busy low at cycle 16.
- Phase stepping and wrap: phase preset via 255 frames at freq_word=16'h0100.
  - rom_addr sequence …, 8'hFE, 8'hFF, 8'h00.
  - Phase register reads 16'h0000 after frame at 8'hFF.
- Overrun: tick at cycle 5 of a frame.
  - overrun=1 for exactly that cycle.
  - SO/soc timing identical to basic frame.
  - No second frame starts.
- Back-to-back ticks every 16 cycles for 10 frames: no overrun, soc every 16 cycles, rom_addr increments by 1.
- Abort: en driven 0 during SHIFT bit 4.
  - Next cycle: IDLE, SI_en=0, soc never asserted.
  - Phase unchanged; next frame reuses the same rom_addr.
- Async reset mid-frame: rst_n=0 during SHIFT, asynchronously to clk.
  - All outputs 0 immediately; phase=0.
  - After release, first tick gives rom_addr=0.

Source files
------------

// File: rtl/sine_dac_pkg.sv
// ============================================================================
//  Module      : sine_dac_pkg
//  Description : Shared types and default sizes for the serial sine DAC path.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package sine_dac_pkg;

  localparam int SINE_DATA_W  = 12;
  localparam int SINE_ADDR_W  = 8;
  localparam int SINE_PHASE_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    SHIFT   = 3'd3,
    CONVERT = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/dac_frame_sequencer_piso.sv
// ============================================================================
//  Module      : dac_piso
//  Description : Parallel-load, MSB-first shift register feeding the DAC SI.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dac_piso #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              q_msb
);

  logic [DATA_W-1:0] sreg;

  // Load a whole sample, or move the next bit into the MSB position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= d;
    end else if (shift) begin
      sreg <= sreg << 1;
    end
  end

  assign q_msb = sreg[DATA_W-1];

endmodule

`default_nettype wire

// File: rtl/dac_frame_sequencer.sv
// ============================================================================
//  Module      : dac_frame_sequencer
//  Description : Per-tick ROM fetch, serial shift-out and start-of-conversion
//                strobe for the sine DAC, with phase accumulation.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dac_frame_sequencer
  import sine_dac_pkg::*;
#(
  parameter int DATA_W  = SINE_DATA_W,
  parameter int ADDR_W  = SINE_ADDR_W,
  parameter int PHASE_W = SINE_PHASE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               tick,
  input  logic [PHASE_W-1:0] freq_word,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic               SO,
  output logic               SI_en,
  output logic               soc,
  output logic               busy,
  output logic               overrun
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] freq_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic               piso_load;
  logic               piso_shift;
  logic               piso_msb;
  logic               start;

  assign start = (state_q == IDLE) && en && tick;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and shift-register control; dropping en aborts any frame.
  always_comb begin
    state_d    = state_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    if ((state_q != IDLE) && !en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = FETCH;
        FETCH:   state_d = WAIT;
        WAIT: begin
          piso_load = 1'b1;
          state_d   = SHIFT;
        end
        SHIFT: begin
          piso_shift = 1'b1;
          if (bit_cnt == '0) state_d = CONVERT;
        end
        CONVERT: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame setup, bit counting and phase advance (only on a completed frame).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      freq_q   <= '0;
      rom_addr <= '0;
      bit_cnt  <= '0;
    end else begin
      if (start) begin
        freq_q   <= freq_word;
        rom_addr <= phase[PHASE_W-1 -: ADDR_W];
      end
      if (piso_load) begin
        bit_cnt <= CNT_LAST;
      end else if (piso_shift && (bit_cnt != '0)) begin
        bit_cnt <= bit_cnt - 1'b1;
      end
      if ((state_q == CONVERT) && en) begin
        phase <= phase + freq_q;
      end
    end
  end

  // Status outputs are registered from the next state so they line up with it;
  // overrun appears the cycle after the offending tick is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      SI_en   <= 1'b0;
      soc     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      busy    <= (state_d != IDLE);
      SI_en   <= (state_d == SHIFT);
      soc     <= (state_d == CONVERT);
      overrun <= tick && (state_q != IDLE);
    end
  end

  dac_piso #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (piso_load),
    .shift (piso_shift),
    .d     (rom_data),
    .q_msb (piso_msb)
  );

  // Serial data is held low whenever the shift enable is low.
  assign SO = piso_msb & SI_en;

endmodule

`default_nettype wire

// File: tb/tb_dac_frame_sequencer.sv
// ============================================================================
//  Module      : tb_dac_frame_sequencer
//  Description : Self-checking bench for dac_frame_sequencer with a ROM model
//                and a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dac_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        tick;
  logic [15:0] freq_word;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic        SO;
  logic        SI_en;
  logic        soc;
  logic        busy;
  logic        overrun;

  logic [11:0] rom [256];
  logic [15:0] exp_phase;
  int          n_assert = 0;
  int          n_fail   = 0;

  dac_frame_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .tick      (tick),
    .freq_word (freq_word),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .SO        (SO),
    .SI_en     (SI_en),
    .soc       (soc),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One full frame started by a tick in the current cycle (cycle 0).
  // ovr_cyc > 0 adds a stray tick in that cycle; overrun shows the next cycle.
  task automatic frame(input logic [15:0] f, input int ovr_cyc);
    logic [7:0]  a;
    logic [11:0] w;
    a = exp_phase[15:8];
    w = rom[a];
    en = 1'b1;
    tick = 1'b1;
    freq_word = f;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      tick = (c == ovr_cyc);
      if (c == 4) freq_word = 16'($urandom);
      chk($sformatf("busy c%0d", c), 32'(busy), 32'(c <= 15));
      chk($sformatf("rom_addr c%0d", c), 32'(rom_addr), 32'(a));
      chk($sformatf("si_en c%0d", c), 32'(SI_en), 32'(c >= 3 && c <= 14));
      chk($sformatf("so c%0d", c), 32'(SO), 32'((c >= 3 && c <= 14) ? w[14-c] : 1'b0));
      chk($sformatf("soc c%0d", c), 32'(soc), 32'(c == 15));
      chk($sformatf("overrun c%0d", c), 32'(overrun), 32'(ovr_cyc > 0 && c == ovr_cyc + 1));
    end
    exp_phase = exp_phase + f;
    chk("phase after frame", 32'(dut.phase), 32'(exp_phase));
  endtask

  // Idle cycles with en low and random ticks: nothing may start.
  task automatic idle(input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle overrun", 32'(overrun), 32'd0);
      chk("idle si_en", 32'(SI_en | SO | soc), 32'd0);
    end
    tick = 1'b0;
    en = 1'b1;
  endtask

  // Frame aborted by en low while bit DATA_W-1-4 is on the line.
  task automatic abort_frame(input logic [15:0] f);
    logic [7:0]  a;
    logic [11:0] w;
    a = exp_phase[15:8];
    w = rom[a];
    en = 1'b1;
    tick = 1'b1;
    freq_word = f;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      tick = 1'b0;
      chk("abort busy", 32'(busy), 32'd1);
      chk("abort so", 32'(SO), 32'((c >= 3) ? w[14-c] : 1'b0));
    end
    en = 1'b0;
    for (int c = 8; c <= 20; c++) begin
      @(posedge clk); #1;
      chk("abort idle busy", 32'(busy), 32'd0);
      chk("abort si_en", 32'(SI_en), 32'd0);
      chk("abort so off", 32'(SO), 32'd0);
      chk("abort soc", 32'(soc), 32'd0);
      chk("abort rom_addr hold", 32'(rom_addr), 32'(a));
    end
    chk("abort phase held", 32'(dut.phase), 32'(exp_phase));
    en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 12'($urandom);
    rom[0] = 12'hA5C;
    rst_n = 1'b0;
    en = 1'b0;
    tick = 1'b0;
    freq_word = 16'h0000;
    exp_phase = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset outs", 32'({SO, SI_en, soc, overrun}), 32'd0);
    chk("reset rom_addr", 32'(rom_addr), 32'd0);
    chk("reset phase", 32'(dut.phase), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Basic frame: ROM[0]=A5C shifted out MSB-first.
    frame(16'h0100, 0);

    // Step through all addresses and wrap back to 0.
    for (int i = 0; i < 256; i++) begin
      frame(16'h0100, 0);
      if (rom_addr == 8'hFF) chk("phase wrap to 0", 32'(dut.phase), 32'd0);
    end

    // Stray tick in cycle 5; no second frame must follow.
    frame(16'h0100, 5);
    @(posedge clk); #1;
    chk("no second frame", 32'(busy), 32'd0);

    // Back-to-back frames at minimum tick period.
    for (int i = 0; i < 10; i++) frame(16'h0100, 0);

    // Random frequency words, random stray ticks, random idle gaps.
    for (int i = 0; i < 20; i++) begin
      frame(16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0);
      idle(int'($urandom_range(0, 4)));
    end

    // Abort mid-shift, then the next frame reuses the same address.
    abort_frame(16'h1234);
    frame(16'h0100, 0);

    // Asynchronous reset in the middle of a frame.
    en = 1'b1;
    tick = 1'b1;
    freq_word = 16'h0300;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      tick = 1'b0;
    end
    #3 rst_n = 1'b0;
    #1;
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst outs", 32'({SO, SI_en, soc, overrun}), 32'd0);
    chk("async rst rom_addr", 32'(rom_addr), 32'd0);
    chk("async rst phase", 32'(dut.phase), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_phase = 16'h0000;
    frame(16'h0040, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
